// File: rtl/nes_kbd_pad.sv
// nes_kbd_pad: maps a USB keyboard onto two NES controller ports.
//
// Three HID keycode slots are synchronised and decoded into two button bytes.
// Each button byte feeds an 8-bit parallel-load shift register that behaves
// like a 4021 inside a real pad. A write to $4016 sets the strobe level.
// A read of $4016 or $4017 shifts the matching pad register.
//
// Ports:
//   clk, reset          system clock (rising edge) and async active-high reset
//   keycode0..2         HID keycode slots (0x00 = no key)
//   strobe_wr/din       $4016 write pulse and its data bit 0
//   rd_p1, rd_p2        $4016 / $4017 read pulses
//   p1_d0, p2_d0        serial data bit presented to the CPU (register LSB)
//   strobe              current latched strobe level
//   buttons_p1/p2       registered live button state, bit0..7 = A,B,Sel,Start,U,D,L,R
module nes_kbd_pad #(
  parameter logic        POST_READ_VAL = 1'b1,
  parameter int unsigned SOCD_MASK     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic       strobe_wr,
  input  logic       strobe_din,
  input  logic       rd_p1,
  input  logic       rd_p2,
  output logic       p1_d0,
  output logic       p2_d0,
  output logic       strobe,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2
);

  logic [2:0][7:0] kc_meta;
  logic [2:0][7:0] kc_sync;
  logic [7:0]      raw_p1;
  logic [7:0]      raw_p2;
  logic [7:0]      dec_p1;
  logic [7:0]      dec_p2;
  logic [7:0]      sr_p1;
  logic [7:0]      sr_p2;

  function automatic logic key_hit(input logic [2:0][7:0] kc, input logic [7:0] code);
    return (kc[0] == code) || (kc[1] == code) || (kc[2] == code);
  endfunction

  // An opposing pair that is held together reads as neither direction.
  function automatic logic [7:0] socd_filter(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (SOCD_MASK != 0) begin
      if (b[4] && b[5]) r[5:4] = 2'b00;
      if (b[6] && b[7]) r[7:6] = 2'b00;
    end
    return r;
  endfunction

  always_comb begin
    raw_p1 = '0;
    raw_p1[0] = key_hit(kc_sync, 8'h0D);
    raw_p1[1] = key_hit(kc_sync, 8'h0E);
    raw_p1[2] = key_hit(kc_sync, 8'h2B);
    raw_p1[3] = key_hit(kc_sync, 8'h28);
    raw_p1[4] = key_hit(kc_sync, 8'h1A);
    raw_p1[5] = key_hit(kc_sync, 8'h16);
    raw_p1[6] = key_hit(kc_sync, 8'h04);
    raw_p1[7] = key_hit(kc_sync, 8'h07);

    raw_p2 = '0;
    raw_p2[0] = key_hit(kc_sync, 8'h59);
    raw_p2[1] = key_hit(kc_sync, 8'h5A);
    raw_p2[2] = key_hit(kc_sync, 8'h5B);
    raw_p2[3] = key_hit(kc_sync, 8'h5C);
    raw_p2[4] = key_hit(kc_sync, 8'h52);
    raw_p2[5] = key_hit(kc_sync, 8'h51);
    raw_p2[6] = key_hit(kc_sync, 8'h50);
    raw_p2[7] = key_hit(kc_sync, 8'h4F);

    dec_p1 = socd_filter(raw_p1);
    dec_p2 = socd_filter(raw_p2);
  end

  // Two-flop synchroniser followed by the registered decode. A keycode change
  // therefore reaches buttons_px on the third clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc_meta    <= '0;
      kc_sync    <= '0;
      buttons_p1 <= '0;
      buttons_p2 <= '0;
    end else begin
      kc_meta    <= {keycode2, keycode1, keycode0};
      kc_sync    <= kc_meta;
      buttons_p1 <= dec_p1;
      buttons_p2 <= dec_p2;
    end
  end

  // The reload/shift decision uses the strobe value from before this edge's
  // write. A 1->0 write therefore performs one last reload, and a read that
  // coincides with any write is judged by the old strobe level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe <= 1'b0;
      sr_p1  <= '0;
      sr_p2  <= '0;
    end else begin
      if (strobe_wr) strobe <= strobe_din;
      if (strobe) begin
        sr_p1 <= buttons_p1;
        sr_p2 <= buttons_p2;
      end else begin
        if (rd_p1) sr_p1 <= {POST_READ_VAL, sr_p1[7:1]};
        if (rd_p2) sr_p2 <= {POST_READ_VAL, sr_p2[7:1]};
      end
    end
  end

  assign p1_d0 = sr_p1[0];
  assign p2_d0 = sr_p2[0];

endmodule

// File: tb/tb_nes_kbd_pad.sv
// Self-checking bench for nes_kbd_pad. A second instance built with SOCD_MASK=0
// shares all inputs so the opposing-direction filter can be compared both ways.
// Expected serial bits are queued when a strobe snapshot is taken and popped
// as each read is issued.
module tb_nes_kbd_pad;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] keycode0, keycode1, keycode2;
  logic       strobe_wr, strobe_din, rd_p1, rd_p2;
  logic       p1_d0, p2_d0, strobe;
  logic [7:0] buttons_p1, buttons_p2;
  logic       n_p1_d0, n_p2_d0, n_strobe;
  logic [7:0] n_buttons_p1, n_buttons_p2;

  int checks = 0;
  int errors = 0;
  logic q1[$];
  logic q2[$];

  always #5 clk = ~clk;

  nes_kbd_pad #(.POST_READ_VAL(1'b1), .SOCD_MASK(1)) dut (
    .clk(clk), .reset(reset),
    .keycode0(keycode0), .keycode1(keycode1), .keycode2(keycode2),
    .strobe_wr(strobe_wr), .strobe_din(strobe_din),
    .rd_p1(rd_p1), .rd_p2(rd_p2),
    .p1_d0(p1_d0), .p2_d0(p2_d0), .strobe(strobe),
    .buttons_p1(buttons_p1), .buttons_p2(buttons_p2)
  );

  nes_kbd_pad #(.POST_READ_VAL(1'b1), .SOCD_MASK(0)) dut_nosocd (
    .clk(clk), .reset(reset),
    .keycode0(keycode0), .keycode1(keycode1), .keycode2(keycode2),
    .strobe_wr(strobe_wr), .strobe_din(strobe_din),
    .rd_p1(rd_p1), .rd_p2(rd_p2),
    .p1_d0(n_p1_d0), .p2_d0(n_p2_d0), .strobe(n_strobe),
    .buttons_p1(n_buttons_p1), .buttons_p2(n_buttons_p2)
  );

  // One rising edge, then return to the falling edge where inputs change and outputs are sampled.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    keycode0 = a;
    keycode1 = b;
    keycode2 = c;
  endtask

  // Strobe 1 then 0. The falling write takes the snapshot.
  task automatic strobe_pulse();
    strobe_wr = 1'b1; strobe_din = 1'b1; tick(1);
    strobe_din = 1'b0; tick(1);
    strobe_wr = 1'b0;
  endtask

  task automatic push_byte(input int pad, input logic [7:0] b, input int extra_post);
    for (int i = 0; i < 8; i++) begin
      if (pad == 1) q1.push_back(b[i]); else q2.push_back(b[i]);
    end
    for (int i = 0; i < extra_post; i++) begin
      if (pad == 1) q1.push_back(1'b1); else q2.push_back(1'b1);
    end
  endtask

  task automatic test_reset();
    logic [7:0] e;
    reset = 1'b1;
    set_keys(8'h00, 8'h00, 8'h00);
    strobe_wr = 0; strobe_din = 0; rd_p1 = 0; rd_p2 = 0;
    tick(2);
    checks++; if ({p1_d0, p2_d0, strobe} !== 3'b000) begin errors++;
      $display("FAIL reset_outs got %b exp 000", {p1_d0, p2_d0, strobe}); end
    checks++; if (buttons_p1 !== 8'h00 || buttons_p2 !== 8'h00) begin errors++;
      $display("FAIL reset_buttons got %h/%h exp 00/00", buttons_p1, buttons_p2); end
    reset = 1'b0;
    tick(5);
    e = 8'h00;
    checks++; if ({p1_d0, p2_d0, strobe} !== 3'b000 || buttons_p1 !== e) begin errors++;
      $display("FAIL idle_after_reset got %b %h exp 000 00", {p1_d0, p2_d0, strobe}, buttons_p1); end
  endtask

  task automatic test_p1_sequence();
    logic e;
    set_keys(8'h0D, 8'h28, 8'h00);
    tick(4);
    checks++; if (buttons_p1 !== 8'h09) begin errors++;
      $display("FAIL p1_buttons got %h exp 09", buttons_p1); end
    strobe_pulse();
    push_byte(1, 8'h09, 2);
    for (int i = 0; i < 10; i++) begin
      e = q1.pop_front();
      checks++; if (p1_d0 !== e) begin errors++;
        $display("FAIL p1_read%0d got %b exp %b", i + 1, p1_d0, e); end
      if (i == 4) set_keys(8'h00, 8'h00, 8'h00);  // must not disturb the sequence
      rd_p1 = 1'b1; tick(1); rd_p1 = 1'b0;
    end
    checks++; if (p2_d0 !== 1'b0) begin errors++;
      $display("FAIL p2_untouched got %b exp 0", p2_d0); end
  endtask

  task automatic test_p2_dual_read();
    logic e1, e2;
    set_keys(8'h52, 8'h00, 8'h4F);
    tick(4);
    checks++; if (buttons_p2 !== 8'h90) begin errors++;
      $display("FAIL p2_buttons got %h exp 90", buttons_p2); end
    strobe_pulse();
    push_byte(2, 8'h90, 0);
    push_byte(1, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      checks++; if (p2_d0 !== e2) begin errors++;
        $display("FAIL p2_read%0d got %b exp %b", i + 1, p2_d0, e2); end
      checks++; if (p1_d0 !== e1) begin errors++;
        $display("FAIL p1_dual_read%0d got %b exp %b", i + 1, p1_d0, e1); end
      rd_p1 = 1'b1; rd_p2 = 1'b1; tick(1); rd_p1 = 1'b0; rd_p2 = 1'b0;
    end
    checks++; if ({p1_d0, p2_d0} !== 2'b11) begin errors++;
      $display("FAIL dual_post got %b exp 11", {p1_d0, p2_d0}); end
  endtask

  task automatic test_socd();
    set_keys(8'h1A, 8'h16, 8'h00);
    tick(4);
    checks++; if (buttons_p1 !== 8'h00) begin errors++;
      $display("FAIL socd_ud_masked got %h exp 00", buttons_p1); end
    checks++; if (n_buttons_p1 !== 8'h30) begin errors++;
      $display("FAIL socd_ud_unmasked got %h exp 30", n_buttons_p1); end
    set_keys(8'h50, 8'h4F, 8'h59);
    tick(4);
    checks++; if (buttons_p2 !== 8'h01) begin errors++;
      $display("FAIL socd_lr_masked got %h exp 01", buttons_p2); end
    checks++; if (n_buttons_p2 !== 8'hC1) begin errors++;
      $display("FAIL socd_lr_unmasked got %h exp c1", n_buttons_p2); end
  endtask

  task automatic test_strobe_hold();
    logic [7:0] exp_b [3];
    exp_b = '{8'h00, 8'h00, 8'h02};
    set_keys(8'h00, 8'h00, 8'h00);
    strobe_wr = 1'b1; strobe_din = 1'b1; tick(1); strobe_wr = 1'b0;
    tick(4);
    rd_p1 = 1'b1;
    keycode0 = 8'h0E;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (buttons_p1 !== exp_b[i]) begin errors++;
        $display("FAIL hold_latency%0d got %h exp %h", i + 1, buttons_p1, exp_b[i]); end
      checks++; if (p1_d0 !== 1'b0) begin errors++;
        $display("FAIL hold_a_bit%0d got %b exp 0", i + 1, p1_d0); end
    end
    keycode1 = 8'h0D;
    tick(5);
    for (int i = 0; i < 3; i++) begin
      checks++; if (p1_d0 !== 1'b1) begin errors++;
        $display("FAIL hold_no_shift%0d got %b exp 1", i, p1_d0); end
      tick(1);
    end
    rd_p1 = 1'b0;
    strobe_wr = 1'b1; strobe_din = 1'b0; tick(1); strobe_wr = 1'b0;
  endtask

  task automatic test_reset_mid_sequence();
    logic e;
    set_keys(8'h0D, 8'h28, 8'h00);
    tick(4);
    strobe_pulse();
    push_byte(1, 8'h09, 0);
    for (int i = 0; i < 3; i++) begin
      e = q1.pop_front();
      checks++; if (p1_d0 !== e) begin errors++;
        $display("FAIL pre_reset_read%0d got %b exp %b", i + 1, p1_d0, e); end
      rd_p1 = 1'b1; tick(1); rd_p1 = 1'b0;
    end
    e = q1.pop_front();
    checks++; if (p1_d0 !== e) begin errors++;
      $display("FAIL pre_reset_bit3 got %b exp %b", p1_d0, e); end
    q1.delete();
    reset = 1'b1;
    #1;
    checks++; if (p1_d0 !== 1'b0 || strobe !== 1'b0) begin errors++;
      $display("FAIL async_reset got %b%b exp 00", p1_d0, strobe); end
    @(negedge clk);
    reset = 1'b0;
    tick(4);
    strobe_pulse();
    push_byte(1, 8'h09, 0);
    for (int i = 0; i < 8; i++) begin
      e = q1.pop_front();
      checks++; if (p1_d0 !== e) begin errors++;
        $display("FAIL restart_read%0d got %b exp %b", i + 1, p1_d0, e); end
      rd_p1 = 1'b1; tick(1); rd_p1 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    set_keys(8'h0D, 8'h00, 8'h00);
    tick(4);
    strobe_wr = 1'b1; strobe_din = 1'b1; tick(1);
    checks++; if (strobe !== 1'b1) begin errors++;
      $display("FAIL b2b_strobe_set got %b exp 1", strobe); end
    strobe_din = 1'b0; rd_p1 = 1'b1; tick(1);
    strobe_wr = 1'b0; rd_p1 = 1'b0;
    checks++; if (strobe !== 1'b0) begin errors++;
      $display("FAIL b2b_strobe_clear got %b exp 0", strobe); end
    checks++; if (p1_d0 !== 1'b1) begin errors++;
      $display("FAIL b2b_no_shift got %b exp 1", p1_d0); end
    rd_p1 = 1'b1; tick(1); rd_p1 = 1'b0;
    checks++; if (p1_d0 !== 1'b0) begin errors++;
      $display("FAIL b2b_next_shift got %b exp 0", p1_d0); end
  endtask

  initial begin
    test_reset();
    test_p1_sequence();
    test_p2_dual_read();
    test_socd();
    test_strobe_hold();
    test_reset_mid_sequence();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nes_kbd_pad.md
NES_KBD_PAD -- requirements
Module: nes_kbd_pad

Interface
REQ-001 Parameter: POST_READ_VAL, 1'b1, bit shifted into each pad register's MSB per read; returned after 8 reads.
REQ-002 Parameter: SOCD_MASK, 1, when 1 suppress Up+Down and Left+Right pairs pressed together.
REQ-003 Port: clk  input  1  system clock, rising-edge; all logic in this single domain.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: keycode0  input  8  USB HID keycode slot 0 from the soft-core keycode PIO (0x00 = none).
REQ-006 Port: keycode1  input  8  HID keycode slot 1.
REQ-007 Port: keycode2  input  8  HID keycode slot 2.
REQ-008 Port: strobe_wr  input  1  one-cycle pulse: CPU write to $4016.
REQ-009 Port: strobe_din  input  1  bit 0 of the $4016 write data, qualified by strobe_wr.
REQ-010 Port: rd_p1  input  1  one-cycle pulse: CPU read of $4016.
REQ-011 Port: rd_p2  input  1  one-cycle pulse: CPU read of $4017.
REQ-012 Port: p1_d0  output  1  pad-1 serial data, the current shift-register LSB.
REQ-013 Port: p2_d0  output  1  pad-2 serial data, the current shift-register LSB.
REQ-014 Port: strobe  output  1  current latched strobe level.
REQ-015 Port: buttons_p1, buttons_p2  output  8 each  debug snapshot of live button state.

Function
REQ-016 Keycode inputs SHALL pass through a 2-flop synchronizer before decode; a key is pressed if any of the 3 slots equals its code.
REQ-017 Button byte order SHALL be bit0..bit7 = A, B, Select, Start, Up, Down, Left, Right; 1 = pressed.
REQ-018 Pad-1 key map SHALL be: A 0x0D (J), B 0x0E (K), Select 0x2B (Tab), Start 0x28 (Enter), Up 0x1A (W), Down 0x16 (S), Left 0x04 (A), Right 0x07 (D).
REQ-019 Pad-2 key map SHALL be: A 0x59, B 0x5A, Select 0x5B, Start 0x5C (keypad 1-4), Up 0x52, Down 0x51, Left 0x50, Right 0x4F (arrow keys).
REQ-020 When SOCD_MASK=1, an opposing pair pressed together SHALL both decode as 0.
REQ-021 buttons_p1 and buttons_p2 SHALL be registered decode outputs: a keycode change reaches buttons_px 3 cycles later.
REQ-022 strobe_wr SHALL load strobe <= strobe_din on the same clock edge.
REQ-023 While strobe=1, each shift register SHALL reload from buttons_px every cycle, and reads SHALL NOT shift.
REQ-024 When strobe=0, an rd_px pulse SHALL shift that pad's register right by one and insert POST_READ_VAL at bit7; the other pad is unaffected.
REQ-025 p1_d0 and p2_d0 SHALL reflect bit0 combinationally from the register, so the CPU samples the bit before the shift edge.
REQ-026 After 8 reads with strobe=0, p_xd0 SHALL equal POST_READ_VAL indefinitely until the next reload.
REQ-027 strobe_wr together with rd_px in one cycle: the strobe update SHALL be applied, and the shift SHALL be gated by the pre-write strobe value.
REQ-028 rd_p1 and rd_p2 together in one cycle SHALL shift both registers independently.
REQ-029 A 1->0 strobe transition SHALL freeze the register at the snapshot taken on that edge (final reload).
REQ-030 Key changes while strobe=0 SHALL NOT alter an in-progress shift sequence.

Reset
REQ-031 On reset assertion, asynchronously: synchronizers, buttons_px, strobe and both shift registers SHALL be 0, so p1_d0 = p2_d0 = 0.
REQ-032 Reset mid-read-sequence SHALL abort the sequence; the first read after release SHALL follow a fresh strobe.
REQ-033 After reset release, no state change SHALL occur until strobe_wr, rd_px or a keycode change.

Verification
REQ-034 keycode0=0x0D, keycode1=0x28; strobe 1 then 0; 8 rd_p1 -> p1_d0 sequence 1,0,0,1,0,0,0,0; reads 9-10 -> 1,1.
REQ-035 keycode0=0x52, keycode2=0x4F; strobe pulse; 8 rd_p2 -> 0,0,0,0,1,0,0,1; p1 reads all 0 for the first 8.
REQ-036 keycode0=0x1A, keycode1=0x16, SOCD_MASK=1 -> buttons_p1=0x00; with SOCD_MASK=0 -> 0x30.
REQ-037 strobe held 1, keycode0 0x00->0x0E, repeated rd_p1 -> p1_d0 stays at the A bit (0), no shifting; buttons_p1=0x02 3 cycles after the change.
REQ-038 After 3 reads, assert reset for 1 cycle -> p1_d0=0 immediately, strobe=0; re-strobe -> sequence restarts at A.
REQ-039 strobe_wr(din=0) and rd_p1 in the same cycle while strobe=1 -> no shift, strobe=0 next cycle; the next rd_p1 shifts.
